// File: rtl/cordic_phase_sequencer.sv
// Purpose: NCO front end for the cordic sin/cos engine. Steps a Q8.8 phase accumulator
//          in [0, 2*pi), issues one start+theta per sample and hands {sin, cos, phase} downstream.
// Latency/backpressure: sample period = IDLE + ISSUE + engine latency + HOLD; out_valid holds
//          until out_ready, and no new start is issued while a result is held.
// Ports: sys_clk/sys_rst_n (async active-low); en, phase_clr, fcw control; cordic_* engine
//        interface; out_* valid/ready result; busy and sticky timeout_err status.
module cordic_phase_sequencer #(
  parameter int BIT_WIDTH   = 16,
  parameter int PHASE_MOD   = 1608,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 en,
  input  logic                 phase_clr,
  input  logic [BIT_WIDTH-1:0] fcw,
  output logic [BIT_WIDTH-1:0] cordic_theta,
  output logic                 cordic_start,
  input  logic [BIT_WIDTH-1:0] cordic_sin,
  input  logic [BIT_WIDTH-1:0] cordic_cos,
  input  logic                 cordic_valid,
  output logic [BIT_WIDTH-1:0] out_sin,
  output logic [BIT_WIDTH-1:0] out_cos,
  output logic [BIT_WIDTH-1:0] out_phase,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_HOLD  = 4'b1000
  } state_t;

  localparam logic [BIT_WIDTH:0]   MOD_W    = (BIT_WIDTH+1)'(PHASE_MOD);
  localparam logic [BIT_WIDTH-1:0] FCW_MAX  = BIT_WIDTH'(PHASE_MOD - 1);
  localparam logic [7:0]           TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t               state, state_nxt;
  logic [BIT_WIDTH-1:0] phase;
  logic [7:0]           tmo_cnt;

  logic                 load_theta, step, capture, tmo_fire, release_out;
  logic [BIT_WIDTH-1:0] fcw_eff, phase_next;
  logic [BIT_WIDTH:0]   phase_sum;

  // Increment is clamped below one full turn, so a single conditional subtract
  // is enough to keep the accumulator inside [0, PHASE_MOD).
  always_comb begin
    fcw_eff    = (fcw > FCW_MAX) ? FCW_MAX : fcw;
    phase_sum  = {1'b0, phase} + {1'b0, fcw_eff};
    phase_next = phase_sum[BIT_WIDTH-1:0];
    if (phase_sum >= MOD_W) begin
      phase_next = BIT_WIDTH'(phase_sum - MOD_W);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    load_theta   = 1'b0;
    step         = 1'b0;
    capture      = 1'b0;
    tmo_fire     = 1'b0;
    release_out  = 1'b0;
    cordic_start = 1'b0;
    busy         = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (en) begin
          load_theta = 1'b1;
          state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cordic_start = 1'b1;
        step         = 1'b1;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the expiry cycle still counts as an answer.
        if (cordic_valid) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_fire  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          release_out = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase        <= '0;
      cordic_theta <= '0;
      tmo_cnt      <= '0;
      timeout_err  <= 1'b0;
      out_sin      <= '0;
      out_cos      <= '0;
      out_phase    <= '0;
      out_valid    <= 1'b0;
    end else begin
      // Clear beats the ISSUE step; the sample already issued keeps its theta.
      if (phase_clr) begin
        phase <= '0;
      end else if (step) begin
        phase <= phase_next;
      end

      if (load_theta) begin
        cordic_theta <= phase;
      end

      if (step) begin
        tmo_cnt <= '0;
      end else if (state == ST_WAIT && !cordic_valid) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end

      if (phase_clr) begin
        timeout_err <= 1'b0;
      end else if (tmo_fire) begin
        timeout_err <= 1'b1;
      end

      if (capture) begin
        out_sin   <= cordic_sin;
        out_cos   <= cordic_cos;
        out_phase <= cordic_theta;
        out_valid <= 1'b1;
      end else if (release_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Purpose: directed bench for cordic_phase_sequencer with a fixed-latency engine model.
// Latency: model answers 3 cycles after start (sin = theta + 0x1000, cos = theta ^ 0x00FF).
// Backpressure: out_ready driven per scenario.
module tb_cordic_phase_sequencer;

  localparam int BW  = 16;
  localparam int LAT = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          en = 1'b0;
  logic          phase_clr = 1'b0;
  logic [BW-1:0] fcw = '0;
  logic [BW-1:0] cordic_theta;
  logic          cordic_start;
  logic [BW-1:0] cordic_sin = '0;
  logic [BW-1:0] cordic_cos = '0;
  logic          cordic_valid;
  logic [BW-1:0] out_sin, out_cos, out_phase;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          timeout_err;

  logic          model_valid = 1'b0;
  logic          inj_valid = 1'b0;
  logic          mute = 1'b0;
  int            pending = 0;
  logic [BW-1:0] lat_theta = '0;

  int checks = 0;
  int errors = 0;

  assign cordic_valid = model_valid | inj_valid;

  always #5 sys_clk = ~sys_clk;

  cordic_phase_sequencer dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .en           (en),
    .phase_clr    (phase_clr),
    .fcw          (fcw),
    .cordic_theta (cordic_theta),
    .cordic_start (cordic_start),
    .cordic_sin   (cordic_sin),
    .cordic_cos   (cordic_cos),
    .cordic_valid (cordic_valid),
    .out_sin      (out_sin),
    .out_cos      (out_cos),
    .out_phase    (out_phase),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  // Engine model, driven on the falling edge so the DUT samples settled values.
  always @(negedge sys_clk) begin
    model_valid = 1'b0;
    if (!sys_rst_n) begin
      pending = 0;
    end else if (cordic_start && !mute) begin
      pending   = LAT;
      lat_theta = cordic_theta;
    end else if (pending != 0) begin
      pending = pending - 1;
      if (pending == 0) begin
        model_valid = 1'b1;
        cordic_sin  = lat_theta + 16'h1000;
        cordic_cos  = lat_theta ^ 16'h00FF;
      end
    end
  end

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (cordic_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (!busy) break;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle: busy=%0b want 0", busy);
    end
  endtask

  task automatic clear_phase();
    @(negedge sys_clk);
    phase_clr = 1'b1;
    @(negedge sys_clk);
    phase_clr = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({cordic_theta, out_sin, out_cos, out_phase} !== '0 ||
        {cordic_start, out_valid, busy, timeout_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_state: theta=%0d sin=%0d cos=%0d ph=%0d st=%0b v=%0b b=%0b te=%0b want all 0",
               cordic_theta, out_sin, out_cos, out_phase, cordic_start, out_valid, busy, timeout_err);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_sequence();
    bit ok;
    logic [BW-1:0] exp;
    fcw = 16'd100;
    out_ready = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 18; k++) begin
      exp = (k < 17) ? BW'(k * 100) : 16'd92;
      wait_out(ok);
      checks++;
      if (!ok || out_phase !== exp) begin
        errors++;
        $display("FAIL seq_phase[%0d]: got %0d want %0d (seen=%0b)", k, out_phase, exp, ok);
      end
      checks++;
      if (out_sin !== exp + 16'h1000 || out_cos !== (exp ^ 16'h00FF)) begin
        errors++;
        $display("FAIL seq_data[%0d]: sin=%h cos=%h want %h %h", k, out_sin, out_cos,
                 exp + 16'h1000, exp ^ 16'h00FF);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad = 0;
    int starts = 0;
    clear_phase();
    fcw = 16'd10;
    out_ready = 1'b0;
    en = 1'b1;
    wait_out(ok);
    checks++;
    if (!ok || out_phase !== 16'd0 || out_sin !== 16'h1000) begin
      errors++;
      $display("FAIL bp_first: ph=%0d sin=%h want 0 1000", out_phase, out_sin);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (cordic_start) starts++;
      if (out_valid !== 1'b1 || out_phase !== 16'd0 || out_sin !== 16'h1000 ||
          out_cos !== 16'h00FF) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable cycles want 0", bad);
    end
    checks++;
    if (starts != 0) begin
      errors++;
      $display("FAIL bp_no_start: %0d starts want 0", starts);
    end
    en = 1'b0;
    out_ready = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%0b want 0", out_valid);
    end
    drain();
  endtask

  task automatic test_valid_outside_wait();
    logic [BW-1:0] ph0, s0;
    ph0 = out_phase;
    s0  = out_sin;
    @(negedge sys_clk);
    inj_valid = 1'b1;
    @(negedge sys_clk);
    inj_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_phase !== ph0 || out_sin !== s0) begin
      errors++;
      $display("FAIL stray_valid: v=%0b b=%0b ph=%0d want 0 0 %0d", out_valid, busy, out_phase, ph0);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc = 0;
    int starts = 0;
    clear_phase();
    fcw = 16'd50;
    mute = 1'b1;
    en = 1'b1;
    wait_start(ok);
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      cyc++;
      if (cordic_start) starts++;
      if (timeout_err) break;
    end
    checks++;
    if (!ok || timeout_err !== 1'b1 || cyc != 256) begin
      errors++;
      $display("FAIL tmo_cycles: err=%0b after %0d cycles want 1 after 256", timeout_err, cyc);
    end
    checks++;
    if (busy !== 1'b0 || starts != 0) begin
      errors++;
      $display("FAIL tmo_idle: busy=%0b starts=%0d want 0 0", busy, starts);
    end
    mute = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (cordic_start !== 1'b1 || cordic_theta !== 16'd50) begin
      errors++;
      $display("FAIL tmo_reissue: start=%0b theta=%0d want 1 50", cordic_start, cordic_theta);
    end
    phase_clr = 1'b1;
    @(negedge sys_clk);
    phase_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear: timeout_err=%0b want 0", timeout_err);
    end
    wait_out(ok);
    checks++;
    if (!ok || out_phase !== 16'd50) begin
      errors++;
      $display("FAIL clr_inflight: ph=%0d want 50", out_phase);
    end
    wait_out(ok);
    checks++;
    if (!ok || out_phase !== 16'd0) begin
      errors++;
      $display("FAIL clr_next: ph=%0d want 0", out_phase);
    end
    drain();
  endtask

  task automatic test_saturation();
    bit ok;
    int starts = 0;
    logic [BW-1:0] exp_tab [3];
    exp_tab[0] = 16'd0;
    exp_tab[1] = 16'd1607;
    exp_tab[2] = 16'd1606;
    clear_phase();
    fcw = 16'd2000;
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_out(ok);
      checks++;
      if (!ok || out_phase !== exp_tab[k]) begin
        errors++;
        $display("FAIL sat_phase[%0d]: got %0d want %0d", k, out_phase, exp_tab[k]);
      end
    end
    wait_start(ok);
    @(negedge sys_clk);
    en = 1'b0;
    wait_out(ok);
    checks++;
    if (!ok || out_phase !== 16'd1605) begin
      errors++;
      $display("FAIL en_drop_final: ph=%0d want 1605", out_phase);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (cordic_start) starts++;
    end
    checks++;
    if (busy !== 1'b0 || starts != 0) begin
      errors++;
      $display("FAIL en_drop_quiet: busy=%0b starts=%0d want 0 0", busy, starts);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    fcw = 16'd100;
    en = 1'b1;
    wait_start(ok);
    @(negedge sys_clk);
    checks++;
    if (!ok || busy !== 1'b1 || cordic_theta !== 16'd1604) begin
      errors++;
      $display("FAIL rst_pre: busy=%0b theta=%0d want 1 1604", busy, cordic_theta);
    end
    #1 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({cordic_theta, out_sin, out_cos, out_phase} !== '0 ||
        {cordic_start, out_valid, busy, timeout_err} !== 4'b0) begin
      errors++;
      $display("FAIL rst_async: theta=%0d ph=%0d sin=%0d b=%0b want all 0",
               cordic_theta, out_phase, out_sin, busy);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_start(ok);
    checks++;
    if (!ok || cordic_theta !== 16'd0) begin
      errors++;
      $display("FAIL rst_first_theta: theta=%0d want 0", cordic_theta);
    end
    wait_out(ok);
    checks++;
    if (!ok || out_phase !== 16'd0 || out_sin !== 16'h1000) begin
      errors++;
      $display("FAIL rst_first_out: ph=%0d sin=%h want 0 1000", out_phase, out_sin);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_valid_outside_wait();
    test_timeout();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
